// File: rtl/lcd_responder.sv
// HD44780-compatible bus responder: decodes E-strobed instruction/data writes into a
// 2x16 DDRAM with address counter and busy timing, and answers status/data reads.
module lcd_responder #(
  parameter int BUSY_CYCLES  = 2,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic       clk_1ms,
  input  logic       reset,
  input  logic       E_in,
  input  logic       RW_in,
  input  logic       RS_in,
  input  logic [7:0] DB_in,
  output logic [7:0] DB_out,
  output logic       DB_oe,
  output logic       busy,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       cmd_err,
  input  logic [4:0] rd_idx,
  output logic [7:0] rd_data
);

  localparam int MAX_CYCLES = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] BUSY_LOAD  = CW'(BUSY_CYCLES);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES);
  localparam logic [7:0]    BLANK      = 8'h20;

  logic          e_q, e_d;
  logic [7:0]    ddram_q [32];
  logic [7:0]    ddram_d [32];
  logic [4:0]    ac_q, ac_d;
  logic          id_q, id_d;
  logic          disp_q, disp_d;
  logic          cursor_q, cursor_d;
  logic          blink_q, blink_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          oe_q, oe_d;
  logic [7:0]    dout_q, dout_d;
  logic          err_q, err_d;

  logic       strobe;
  logic       busy_now;
  logic [6:0] ac_ext;

  // The 5-bit index wraps naturally: 0x0F -> 0x40 and 0x4F -> 0x00 going up,
  // and the reverse going down, match plain modulo-32 arithmetic on {line, col}.
  function automatic logic [4:0] ac_step(input logic [4:0] idx, input logic inc);
    return inc ? idx + 5'd1 : idx - 5'd1;
  endfunction

  assign strobe   = e_q & ~E_in;
  assign busy_now = (cnt_q != '0);
  assign ac_ext   = {ac_q[4], 2'b00, ac_q[3:0]};

  always_comb begin
    // NOTE: every _d gets its hold value first so no branch can leave one unassigned (no latches).
    e_d      = E_in;
    ddram_d  = ddram_q;
    ac_d     = ac_q;
    id_d     = id_q;
    disp_d   = disp_q;
    cursor_d = cursor_q;
    blink_d  = blink_q;
    cnt_d    = busy_now ? cnt_q - 1'b1 : cnt_q;
    err_d    = 1'b0;

    oe_d   = E_in & RW_in;
    dout_d = 8'h00;
    if (oe_d) dout_d = RS_in ? ddram_q[ac_q] : {busy_now, ac_ext};

    if (strobe) begin
      if (!RW_in) begin
        if (busy_now) begin
          err_d = 1'b1;
        end else if (RS_in) begin
          ddram_d[ac_q] = DB_in;
          ac_d          = ac_step(ac_q, id_q);
          cnt_d         = BUSY_LOAD;
        end else begin
          // Decode by the highest set bit of the instruction byte.
          casez (DB_in)
            8'b1???????: begin
              ac_d  = {DB_in[6], DB_in[3:0]};
              cnt_d = BUSY_LOAD;
            end
            8'b01??????, 8'b001?????, 8'b0001????: cnt_d = BUSY_LOAD;
            8'b00001???: begin
              disp_d   = DB_in[2];
              cursor_d = DB_in[1];
              blink_d  = DB_in[0];
              cnt_d    = BUSY_LOAD;
            end
            8'b000001??: begin
              id_d  = DB_in[1];
              cnt_d = BUSY_LOAD;
            end
            8'b0000001?: begin
              ac_d  = 5'd0;
              cnt_d = BUSY_LOAD;
            end
            8'b00000001: begin
              for (int i = 0; i < 32; i++) ddram_d[i] = BLANK;
              ac_d  = 5'd0;
              id_d  = 1'b1;
              cnt_d = CLEAR_LOAD;
            end
            default: ;
          endcase
        end
      end else if (RS_in && !busy_now) begin
        ac_d  = ac_step(ac_q, id_q);
        cnt_d = BUSY_LOAD;
      end
    end
  end

  always_ff @(posedge clk_1ms or posedge reset) begin
    if (reset) begin
      e_q      <= 1'b0;
      // NOTE: DDRAM is a flop array (needed for one-cycle clear), so it is reset like any register.
      for (int i = 0; i < 32; i++) ddram_q[i] <= BLANK;
      ac_q     <= 5'd0;
      id_q     <= 1'b1;
      disp_q   <= 1'b0;
      cursor_q <= 1'b0;
      blink_q  <= 1'b0;
      cnt_q    <= '0;
      oe_q     <= 1'b0;
      dout_q   <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
      e_q      <= e_d;
      ddram_q  <= ddram_d;
      ac_q     <= ac_d;
      id_q     <= id_d;
      disp_q   <= disp_d;
      cursor_q <= cursor_d;
      blink_q  <= blink_d;
      cnt_q    <= cnt_d;
      oe_q     <= oe_d;
      dout_q   <= dout_d;
      err_q    <= err_d;
    end
  end

  assign DB_out    = dout_q;
  assign DB_oe     = oe_q;
  assign busy      = busy_now;
  assign disp_on   = disp_q;
  assign cursor_on = cursor_q;
  assign blink_on  = blink_q;
  assign cmd_err   = err_q;
  assign rd_data   = ddram_q[rd_idx];

endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder: a vector table of bus writes followed by
// hand-written sequences for busy rejection, read timing and async reset.
module tb_lcd_responder;

  logic       clk_1ms = 1'b0;
  logic       reset   = 1'b1;
  logic       E_in    = 1'b0;
  logic       RW_in   = 1'b0;
  logic       RS_in   = 1'b0;
  logic [7:0] DB_in   = 8'h00;
  logic [4:0] rd_idx  = 5'd0;
  logic [7:0] DB_out, rd_data;
  logic       DB_oe, busy, disp_on, cursor_on, blink_on, cmd_err;

  int checks   = 0;
  int failures = 0;

  lcd_responder #(.BUSY_CYCLES(2), .CLEAR_CYCLES(4)) dut (
    .clk_1ms  (clk_1ms),
    .reset    (reset),
    .E_in     (E_in),
    .RW_in    (RW_in),
    .RS_in    (RS_in),
    .DB_in    (DB_in),
    .DB_out   (DB_out),
    .DB_oe    (DB_oe),
    .busy     (busy),
    .disp_on  (disp_on),
    .cursor_on(cursor_on),
    .blink_on (blink_on),
    .cmd_err  (cmd_err),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data)
  );

  always #5 clk_1ms = ~clk_1ms;

  typedef struct {
    logic       rs;
    logic [7:0] db;
    logic       exp_busy;
    logic [6:0] exp_ac;
    logic [2:0] exp_dcb;
    logic       chk_mem;
    logic [4:0] idx;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_1ms);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    if (busy) check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  // Raw write: E high one cycle, then the falling-edge strobe cycle; no busy wait.
  task automatic wr_raw(input logic rs, input logic [7:0] db);
    E_in = 1'b1; RW_in = 1'b0; RS_in = rs; DB_in = db;
    tick();
    E_in = 1'b0;
    tick();
  endtask

  task automatic wr(input logic rs, input logic [7:0] db);
    wait_idle();
    wr_raw(rs, db);
  endtask

  task automatic stat_read(output logic [7:0] v);
    E_in = 1'b1; RW_in = 1'b1; RS_in = 1'b0;
    tick();
    check("status_oe", 32'(DB_oe), 32'd1);
    v = DB_out;
    E_in = 1'b0;
    tick();
    RW_in = 1'b0;
  endtask

  task automatic chk_mem(input string name, input logic [4:0] idx, input logic [7:0] exp);
    rd_idx = idx;
    #1;
    check(name, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] st;
    int blanks;

    //            rs    db     busy ac     dcb     mem  idx    data
    vecs[0]  = '{1'b0, 8'h80, 1'b1, 7'h00, 3'b000, 1'b0, 5'd0,  8'h00};
    vecs[1]  = '{1'b1, 8'h41, 1'b1, 7'h01, 3'b000, 1'b1, 5'd0,  8'h41};
    vecs[2]  = '{1'b1, 8'h42, 1'b1, 7'h02, 3'b000, 1'b1, 5'd1,  8'h42};
    vecs[3]  = '{1'b0, 8'h8F, 1'b1, 7'h0F, 3'b000, 1'b0, 5'd0,  8'h00};
    vecs[4]  = '{1'b1, 8'h5A, 1'b1, 7'h40, 3'b000, 1'b1, 5'd15, 8'h5A};
    vecs[5]  = '{1'b0, 8'h04, 1'b1, 7'h40, 3'b000, 1'b0, 5'd0,  8'h00};
    vecs[6]  = '{1'b0, 8'hC0, 1'b1, 7'h40, 3'b000, 1'b0, 5'd0,  8'h00};
    vecs[7]  = '{1'b1, 8'h33, 1'b1, 7'h0F, 3'b000, 1'b1, 5'd16, 8'h33};
    vecs[8]  = '{1'b0, 8'hA3, 1'b1, 7'h03, 3'b000, 1'b0, 5'd0,  8'h00};
    vecs[9]  = '{1'b0, 8'h06, 1'b1, 7'h03, 3'b000, 1'b0, 5'd0,  8'h00};
    vecs[10] = '{1'b0, 8'hCF, 1'b1, 7'h4F, 3'b000, 1'b0, 5'd0,  8'h00};
    vecs[11] = '{1'b1, 8'h55, 1'b1, 7'h00, 3'b000, 1'b1, 5'd31, 8'h55};
    vecs[12] = '{1'b0, 8'h87, 1'b1, 7'h07, 3'b000, 1'b0, 5'd0,  8'h00};
    vecs[13] = '{1'b0, 8'h03, 1'b1, 7'h00, 3'b000, 1'b0, 5'd0,  8'h00};
    vecs[14] = '{1'b0, 8'h0E, 1'b1, 7'h00, 3'b110, 1'b0, 5'd0,  8'h00};
    vecs[15] = '{1'b0, 8'h0D, 1'b1, 7'h00, 3'b101, 1'b0, 5'd0,  8'h00};
    vecs[16] = '{1'b0, 8'h3F, 1'b1, 7'h00, 3'b101, 1'b0, 5'd0,  8'h00};
    vecs[17] = '{1'b0, 8'h7F, 1'b1, 7'h00, 3'b101, 1'b0, 5'd0,  8'h00};
    vecs[18] = '{1'b0, 8'h00, 1'b0, 7'h00, 3'b101, 1'b0, 5'd0,  8'h00};
    vecs[19] = '{1'b0, 8'h04, 1'b1, 7'h00, 3'b101, 1'b0, 5'd0,  8'h00};
    vecs[20] = '{1'b1, 8'h66, 1'b1, 7'h4F, 3'b101, 1'b1, 5'd0,  8'h66};
    vecs[21] = '{1'b0, 8'h06, 1'b1, 7'h4F, 3'b101, 1'b0, 5'd0,  8'h00};

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_oe", 32'(DB_oe), 32'd0);
    check("rst_dout", 32'(DB_out), 32'd0);
    check("rst_cmd_err", 32'(cmd_err), 32'd0);
    check("rst_dcb", 32'({disp_on, cursor_on, blink_on}), 32'd0);
    chk_mem("rst_mem5", 5'd5, 8'h20);
    @(posedge clk_1ms);
    #1 reset = 1'b0;
    tick();
    stat_read(st);
    check("rst_status", 32'(st), 32'h00);

    // Clear: busy for exactly four cycles
    wr(1'b0, 8'h01);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("clear_busy_hi%0d", i), 32'(busy), 32'd1);
      tick();
    end
    check("clear_busy_lo", 32'(busy), 32'd0);
    stat_read(st);
    check("clear_status", 32'(st), 32'h00);
    blanks = 0;
    for (int i = 0; i < 32; i++) begin
      rd_idx = 5'(i);
      #1;
      if (rd_data == 8'h20) blanks++;
    end
    check("clear_all_blank", 32'(blanks), 32'd32);

    // Table of writes
    for (int i = 0; i < 22; i++) begin
      wr(vecs[i].rs, vecs[i].db);
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      wait_idle();
      stat_read(st);
      check($sformatf("v%0d_status", i), 32'(st), 32'({1'b0, vecs[i].exp_ac}));
      check($sformatf("v%0d_dcb", i), 32'({disp_on, cursor_on, blink_on}), 32'(vecs[i].exp_dcb));
      if (vecs[i].chk_mem) chk_mem($sformatf("v%0d_mem", i), vecs[i].idx, vecs[i].data);
    end

    // Write during last busy cycle is rejected with a one-cycle cmd_err
    wr(1'b0, 8'h0E);
    wr_raw(1'b0, 8'h0C);
    check("rej_cmd_err_hi", 32'(cmd_err), 32'd1);
    tick();
    check("rej_cmd_err_lo", 32'(cmd_err), 32'd0);
    check("rej_dcb_kept", 32'({disp_on, cursor_on, blink_on}), 32'b110);

    // Strobe in the first idle cycle is accepted
    wr(1'b0, 8'h80);
    tick();
    wr_raw(1'b1, 8'hAB);
    check("first_idle_busy", 32'(busy), 32'd1);
    check("first_idle_err", 32'(cmd_err), 32'd0);
    chk_mem("first_idle_mem", 5'd0, 8'hAB);

    // Data read: registered DB_out, AC step after the E fall
    wr(1'b0, 8'h85);
    wr(1'b1, 8'h77);
    wr(1'b0, 8'h85);
    wait_idle();
    E_in = 1'b1; RW_in = 1'b1; RS_in = 1'b1;
    tick();
    check("dread_oe", 32'(DB_oe), 32'd1);
    check("dread_dout", 32'(DB_out), 32'h77);
    E_in = 1'b0;
    tick();
    check("dread_busy", 32'(busy), 32'd1);
    check("dread_oe_off", 32'(DB_oe), 32'd0);
    check("dread_dout_off", 32'(DB_out), 32'h00);
    // Data read strobe while busy: ignored, no cmd_err
    E_in = 1'b1;
    tick();
    E_in = 1'b0;
    tick();
    check("dread_busy_err", 32'(cmd_err), 32'd0);
    RW_in = 1'b0; RS_in = 1'b0;
    wait_idle();
    stat_read(st);
    check("dread_ac", 32'(st), 32'h06);

    // Status read while busy reports the busy bit
    wr(1'b0, 8'h8A);
    stat_read(st);
    check("status_busy", 32'(st), 32'h8A);

    // Async reset during clear busy
    wr(1'b0, 8'h01);
    E_in = 1'b1; RW_in = 1'b1; RS_in = 1'b0;
    tick();
    check("pre_rst_oe", 32'(DB_oe), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_oe", 32'(DB_oe), 32'd0);
    check("mid_rst_disp", 32'(disp_on), 32'd0);
    E_in = 1'b0; RW_in = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    stat_read(st);
    check("post_rst_ac", 32'(st), 32'h00);
    wr(1'b1, 8'h99);
    chk_mem("post_rst_mem", 5'd0, 8'h99);
    wait_idle();
    stat_read(st);
    check("post_rst_ac_step", 32'(st), 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
